music_seq_ctrl: RTL and testbench
=================================

Name: music_seq_ctrl

Overview:
- Playback controller for the music player: sequences a song stored in a note ROM and drives the tone generator.
- Steps a ROM address through the song, times each note in beats using a tick-based tempo counter, inserts a one-cycle articulation gap between notes, and handles play/pause/stop/loop user controls.
- Sits between the debounced button inputs and the tone datapath. The ROM is external and combinational.

Parameters:
- ADDR_W, 5, ROM address width (max 32 notes).
- PITCH_W, 4, pitch code width; pitch code 0 = rest.
- TICKS_PER_BEAT, 4, clk cycles per beat (top level overrides with the real tempo value; must be >= 1).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- play  input  1  start/resume request, level sampled each cycle.
- pause  input  1  pause request, level sampled each cycle.
- stop  input  1  abort to idle, level sampled each cycle.
- loop  input  1  when 1, song wraps to note 0 instead of finishing.
- song_len  input  ADDR_W  number of notes in the song (0 = empty song).
- note_pitch  input  PITCH_W  ROM data: pitch at rom_addr.
- note_dur  input  2  ROM data: note length in beats minus 1 (1..4 beats).
- rom_addr  output  ADDR_W  current note address.
- tone_en  output  1  tone generator enable.
- tone_pitch  output  PITCH_W  latched pitch for the tone generator.
- playing  output  1  high in FETCH, PLAY, GAP.
- done  output  1  high in DONE.

Behaviour:
- Reset (async, reset=0): state=IDLE, rom_addr=0, tone_pitch=0, tick and beat counters=0, saved-state=IDLE, all outputs 0. Release is synchronous to the next clk edge.
- States:
  - IDLE: rom_addr held at 0.
  - FETCH: 1 cycle; latches note_pitch to tone_pitch and note_dur to the beat limit; clears the counters.
  - PLAY: lasts (note_dur+1)*TICKS_PER_BEAT cycles; the tick counter wraps at TICKS_PER_BEAT-1 and increments the beat counter.
  - GAP: 1 cycle, tone_en=0.
  - PAUSED: counters and rom_addr frozen.
  - DONE: holds until a control input changes the state.
- Transitions, evaluated each edge. Priority: stop > pause > play.
  - stop=1 in any state -> IDLE, rom_addr=0, tone_pitch=0.
  - IDLE or DONE, play=1:
    - song_len=0 -> DONE.
    - otherwise -> FETCH with rom_addr=0.
  - FETCH -> PLAY.
  - PLAY, last tick of last beat -> GAP.
  - GAP:
    - rom_addr == song_len-1 and loop=0 -> DONE, rom_addr held.
    - rom_addr == song_len-1 and loop=1 -> FETCH, rom_addr=0.
    - otherwise -> FETCH, rom_addr+1.
  - FETCH, PLAY or GAP with pause=1 -> PAUSED; the current state is saved and the counters are not advanced that cycle.
  - PAUSED with play=1 and pause=0 -> saved state; the counters resume from their frozen values.
  - play=1 while already playing is ignored.
- Outputs:
  - tone_en = 1 only in PLAY with tone_pitch != 0. A rest is timed normally but silent.
  - tone_pitch holds its last latched value outside PLAY.
- Arithmetic: rom_addr increments modulo 2^ADDR_W. song_len is compared as unsigned.
- Note latency: the first PLAY cycle is 2 edges after play is sampled in IDLE. Total cycles per note = 1 (FETCH) + (note_dur+1)*TICKS_PER_BEAT + 1 (GAP).

Test Plan (all with TICKS_PER_BEAT=2):
- Reset: drive reset=0 mid-PLAY -> tone_en, playing and rom_addr are 0 immediately, without waiting for clk; state=IDLE after release.
- Two-note song: song_len=2, ROM {0:(pitch 5,dur 0), 1:(pitch 3,dur 1)}, play pulsed 1 cycle. Required sequence:
  - tone_en=1 with tone_pitch=5 for exactly 2 cycles, then tone_en=0 for 1 cycle (GAP).
  - rom_addr=1, then tone_pitch=3 for 4 cycles.
  - GAP, then done=1 with rom_addr=1 held.
- Rest and loop: song_len=1, ROM {0:(pitch 0,dur 0)}, loop=1 -> tone_en stays 0, playing=1, rom_addr stays 0; FETCH recurs every 4 cycles (1+2+1); done never asserts.
- Pause/resume: pause=1 held 5 cycles on the 2nd PLAY cycle of a dur-1 note -> tone_en=0 and the counters are frozen during the pause. After play=1 and pause=0, exactly 3 more PLAY cycles occur before GAP.
- Priority: stop=1, pause=1 and play=1 in the same cycle during PLAY -> IDLE, rom_addr=0. pause=1 and play=1 together while PAUSED -> remains PAUSED.
- Empty song and restart: song_len=0 with play -> DONE on the next edge and tone_en never 1. Then with song_len=2, play in DONE -> FETCH at rom_addr=0.

Source files
------------

// File: rtl/music_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : music_seq_ctrl
// Description : Song playback sequencer: walks a note ROM, times notes in
//               beats, adds a one-cycle gap, handles play/pause/stop/loop.
// Revision    : 1.0 - initial release
// ============================================================================
module music_seq_ctrl #(
    parameter int ADDR_W         = 5,
    parameter int PITCH_W        = 4,
    parameter int TICKS_PER_BEAT = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               play,
    input  logic               pause,
    input  logic               stop,
    input  logic               loop,
    input  logic [ADDR_W-1:0]  song_len,
    input  logic [PITCH_W-1:0] note_pitch,
    input  logic [1:0]         note_dur,
    output logic [ADDR_W-1:0]  rom_addr,
    output logic               tone_en,
    output logic [PITCH_W-1:0] tone_pitch,
    output logic               playing,
    output logic               done
);

    localparam int c_TICK_W = (TICKS_PER_BEAT > 1) ? $clog2(TICKS_PER_BEAT) : 1;

    localparam logic [c_TICK_W-1:0] c_TICK_LAST = c_TICK_W'(TICKS_PER_BEAT - 1);
    localparam logic [c_TICK_W-1:0] c_TICK_ONE  = c_TICK_W'(1);
    localparam logic [ADDR_W-1:0]   c_ADDR_ONE  = ADDR_W'(1);

    localparam logic [2:0] c_S_IDLE   = 3'd0;
    localparam logic [2:0] c_S_FETCH  = 3'd1;
    localparam logic [2:0] c_S_PLAY   = 3'd2;
    localparam logic [2:0] c_S_GAP    = 3'd3;
    localparam logic [2:0] c_S_PAUSED = 3'd4;
    localparam logic [2:0] c_S_DONE   = 3'd5;

    logic [2:0]          r_state, w_state;
    logic [2:0]          r_saved, w_saved;
    logic [ADDR_W-1:0]   r_addr,  w_addr;
    logic [PITCH_W-1:0]  r_pitch, w_pitch;
    logic [1:0]          r_lim,   w_lim;
    logic [1:0]          r_beat,  w_beat;
    logic [c_TICK_W-1:0] r_tick,  w_tick;
    logic                w_last_note;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= c_S_IDLE;
            r_saved <= c_S_IDLE;
            r_addr  <= '0;
            r_pitch <= '0;
            r_lim   <= '0;
            r_beat  <= '0;
            r_tick  <= '0;
        end else begin
            r_state <= w_state;
            r_saved <= w_saved;
            r_addr  <= w_addr;
            r_pitch <= w_pitch;
            r_lim   <= w_lim;
            r_beat  <= w_beat;
            r_tick  <= w_tick;
        end
    end

    always_comb begin
        w_state     = r_state;
        w_saved     = r_saved;
        w_addr      = r_addr;
        w_pitch     = r_pitch;
        w_lim       = r_lim;
        w_beat      = r_beat;
        w_tick      = r_tick;
        w_last_note = (r_addr == (song_len - c_ADDR_ONE));

        if (stop) begin
            w_state = c_S_IDLE;
            w_addr  = '0;
            w_pitch = '0;
        end else begin
            case (r_state)
                c_S_IDLE, c_S_DONE: begin
                    if (play) begin
                        if (song_len == '0) begin
                            w_state = c_S_DONE;
                        end else begin
                            w_state = c_S_FETCH;
                            w_addr  = '0;
                        end
                    end
                end
                c_S_FETCH: begin
                    if (pause) begin
                        w_saved = c_S_FETCH;
                        w_state = c_S_PAUSED;
                    end else begin
                        w_pitch = note_pitch;
                        w_lim   = note_dur;
                        w_tick  = '0;
                        w_beat  = '0;
                        w_state = c_S_PLAY;
                    end
                end
                c_S_PLAY: begin
                    if (pause) begin
                        w_saved = c_S_PLAY;
                        w_state = c_S_PAUSED;
                    end else if (r_tick == c_TICK_LAST) begin
                        w_tick = '0;
                        if (r_beat == r_lim) begin
                            w_state = c_S_GAP;
                        end else begin
                            w_beat = r_beat + 2'd1;
                        end
                    end else begin
                        w_tick = r_tick + c_TICK_ONE;
                    end
                end
                c_S_GAP: begin
                    if (pause) begin
                        w_saved = c_S_GAP;
                        w_state = c_S_PAUSED;
                    end else if (w_last_note) begin
                        if (loop) begin
                            w_state = c_S_FETCH;
                            w_addr  = '0;
                        end else begin
                            w_state = c_S_DONE;
                        end
                    end else begin
                        w_state = c_S_FETCH;
                        w_addr  = r_addr + c_ADDR_ONE;
                    end
                end
                c_S_PAUSED: begin
                    // Resume needs play without pause; both together keep us parked.
                    if (play && !pause) begin
                        w_state = r_saved;
                    end
                end
                default: begin
                    w_state = c_S_IDLE;
                end
            endcase
        end
    end

    assign rom_addr   = r_addr;
    assign tone_pitch = r_pitch;
    assign tone_en    = (r_state == c_S_PLAY) && (r_pitch != '0);
    assign playing    = (r_state == c_S_FETCH) || (r_state == c_S_PLAY) ||
                        (r_state == c_S_GAP);
    assign done       = (r_state == c_S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_music_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_music_seq_ctrl
// Description : Self-checking bench for music_seq_ctrl against a note-level
//               reference model (remaining-cycle countdown per note).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_music_seq_ctrl;

    localparam int c_T = 2;

    localparam int c_M_IDLE   = 0;
    localparam int c_M_FETCH  = 1;
    localparam int c_M_PLAY   = 2;
    localparam int c_M_GAP    = 3;
    localparam int c_M_PAUSED = 4;
    localparam int c_M_DONE   = 5;

    logic       clk = 1'b0;
    logic       reset;
    logic       play, pause, stop, loop;
    logic [4:0] song_len;
    logic [3:0] note_pitch;
    logic [1:0] note_dur;
    logic [4:0] rom_addr;
    logic       tone_en;
    logic [3:0] tone_pitch;
    logic       playing, done;

    logic [3:0] rom_p [32];
    logic [1:0] rom_d [32];

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    int         m_st, m_saved, m_rem;
    logic [4:0] m_addr;
    logic [3:0] m_pitch;

    logic [11:0] w_dut_vec;

    music_seq_ctrl #(
        .ADDR_W         (5),
        .PITCH_W        (4),
        .TICKS_PER_BEAT (c_T)
    ) u_dut (
        .clk        (clk),
        .reset      (reset),
        .play       (play),
        .pause      (pause),
        .stop       (stop),
        .loop       (loop),
        .song_len   (song_len),
        .note_pitch (note_pitch),
        .note_dur   (note_dur),
        .rom_addr   (rom_addr),
        .tone_en    (tone_en),
        .tone_pitch (tone_pitch),
        .playing    (playing),
        .done       (done)
    );

    assign note_pitch = rom_p[rom_addr];
    assign note_dur   = rom_d[rom_addr];
    assign w_dut_vec  = {rom_addr, tone_en, tone_pitch, playing, done};

    always #5 clk = ~clk;

    task automatic model_reset();
        m_st    = c_M_IDLE;
        m_saved = c_M_IDLE;
        m_rem   = 0;
        m_addr  = '0;
        m_pitch = '0;
    endtask

    // One clock edge of the song rules, using the inputs currently driven.
    task automatic model_step();
        logic [4:0] lm1;
        lm1 = song_len - 5'd1;
        if (stop) begin
            m_st    = c_M_IDLE;
            m_addr  = '0;
            m_pitch = '0;
        end else begin
            case (m_st)
                c_M_IDLE, c_M_DONE: begin
                    if (play) begin
                        if (song_len == 5'd0) m_st = c_M_DONE;
                        else begin
                            m_st   = c_M_FETCH;
                            m_addr = '0;
                        end
                    end
                end
                c_M_FETCH, c_M_PLAY, c_M_GAP: begin
                    if (pause) begin
                        m_saved = m_st;
                        m_st    = c_M_PAUSED;
                    end else if (m_st == c_M_FETCH) begin
                        m_pitch = rom_p[m_addr];
                        m_rem   = (int'(rom_d[m_addr]) + 1) * c_T;
                        m_st    = c_M_PLAY;
                    end else if (m_st == c_M_PLAY) begin
                        m_rem = m_rem - 1;
                        if (m_rem == 0) m_st = c_M_GAP;
                    end else if (m_addr == lm1) begin
                        if (loop) begin
                            m_st   = c_M_FETCH;
                            m_addr = '0;
                        end else begin
                            m_st = c_M_DONE;
                        end
                    end else begin
                        m_st   = c_M_FETCH;
                        m_addr = m_addr + 5'd1;
                    end
                end
                c_M_PAUSED: begin
                    if (play && !pause) m_st = m_saved;
                end
                default: m_st = c_M_IDLE;
            endcase
        end
    endtask

    function automatic logic [11:0] exp_vec();
        logic te, pl, dn;
        te = (m_st == c_M_PLAY) && (m_pitch != 4'd0);
        pl = (m_st == c_M_FETCH) || (m_st == c_M_PLAY) || (m_st == c_M_GAP);
        dn = (m_st == c_M_DONE);
        return {m_addr, te, m_pitch, pl, dn};
    endfunction

    task automatic do_cycle();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        play  = 1'b0;
        pause = 1'b0;
        stop  = 1'b0;
    endtask

    task automatic test_reset();
        int k;
        reset = 1'b0;
        clear_inputs();
        loop     = 1'b0;
        song_len = 5'd0;
        #12;
        if (w_dut_vec !== 12'h000) begin
            n_bad++;
            $display("FAIL reset_state: got %h want %h", w_dut_vec, 12'h000);
        end
        n_cmp++;
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        rom_p[0] = 4'd5; rom_d[0] = 2'd0;
        rom_p[1] = 4'd3; rom_d[1] = 2'd1;
        song_len = 5'd2;
        play = 1'b1;
        do_cycle();
        play = 1'b0;
        k = 0;
        while (!(rom_addr == 5'd1 && tone_en) && k < 20) begin
            do_cycle();
            if (w_dut_vec !== exp_vec()) begin
                n_bad++;
                $display("FAIL reset_prelude cyc %0d: got %h want %h", k, w_dut_vec, exp_vec());
            end
            n_cmp++;
            k++;
        end
        if (k >= 20) begin
            n_bad++;
            $display("FAIL reset_reach_play: got timeout want second note playing");
        end
        n_cmp++;
        #2;
        reset = 1'b0;
        #1;
        if ({tone_en, playing, rom_addr} !== 7'd0) begin
            n_bad++;
            $display("FAIL reset_async: got %b want 0", {tone_en, playing, rom_addr});
        end
        n_cmp++;
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        do_cycle();
        if (w_dut_vec !== 12'h000) begin
            n_bad++;
            $display("FAIL reset_release_idle: got %h want %h", w_dut_vec, 12'h000);
        end
        n_cmp++;
    endtask

    task automatic test_two_note();
        int c5, c3, first_on;
        c5 = 0; c3 = 0; first_on = -1;
        rom_p[0] = 4'd5; rom_d[0] = 2'd0;
        rom_p[1] = 4'd3; rom_d[1] = 2'd1;
        song_len = 5'd2;
        loop = 1'b0;
        play = 1'b1;
        do_cycle();
        play = 1'b0;
        for (int i = 0; i < 12; i++) begin
            do_cycle();
            if (w_dut_vec !== exp_vec()) begin
                n_bad++;
                $display("FAIL two_note cyc %0d: got %h want %h", i, w_dut_vec, exp_vec());
            end
            n_cmp++;
            if (tone_en && first_on < 0) first_on = i;
            if (tone_en && tone_pitch == 4'd5) c5++;
            if (tone_en && tone_pitch == 4'd3) c3++;
        end
        if (first_on !== 0) begin
            n_bad++;
            $display("FAIL two_note_latency: got %0d want 0", first_on);
        end
        n_cmp++;
        if (c5 !== 2 || c3 !== 4) begin
            n_bad++;
            $display("FAIL two_note_lengths: got %0d/%0d want 2/4", c5, c3);
        end
        n_cmp++;
        if (done !== 1'b1 || rom_addr !== 5'd1) begin
            n_bad++;
            $display("FAIL two_note_done: got done=%b addr=%0d want done=1 addr=1", done, rom_addr);
        end
        n_cmp++;
    endtask

    task automatic test_rest_loop();
        int n_te, n_dn, n_np, n_ad;
        n_te = 0; n_dn = 0; n_np = 0; n_ad = 0;
        rom_p[0] = 4'd0; rom_d[0] = 2'd0;
        song_len = 5'd1;
        loop = 1'b1;
        play = 1'b1;
        do_cycle();
        play = 1'b0;
        for (int i = 0; i < 20; i++) begin
            do_cycle();
            if (w_dut_vec !== exp_vec()) begin
                n_bad++;
                $display("FAIL rest_loop cyc %0d: got %h want %h", i, w_dut_vec, exp_vec());
            end
            n_cmp++;
            if (tone_en) n_te++;
            if (done) n_dn++;
            if (!playing) n_np++;
            if (rom_addr != 5'd0) n_ad++;
        end
        if (n_te + n_dn + n_np + n_ad !== 0) begin
            n_bad++;
            $display("FAIL rest_loop_flags: got te=%0d dn=%0d np=%0d ad=%0d want all 0", n_te, n_dn, n_np, n_ad);
        end
        n_cmp++;
        stop = 1'b1;
        do_cycle();
        stop = 1'b0;
        loop = 1'b0;
    endtask

    task automatic test_pause();
        int cnt;
        rom_p[0] = 4'd7; rom_d[0] = 2'd1;
        song_len = 5'd1;
        play = 1'b1;
        do_cycle();
        play = 1'b0;
        do_cycle();
        do_cycle();
        if (tone_en !== 1'b1) begin
            n_bad++;
            $display("FAIL pause_setup: got tone_en=%b want 1", tone_en);
        end
        n_cmp++;
        pause = 1'b1;
        for (int i = 0; i < 5; i++) begin
            do_cycle();
            if (tone_en !== 1'b0 || w_dut_vec !== exp_vec()) begin
                n_bad++;
                $display("FAIL pause_hold cyc %0d: got %h want %h", i, w_dut_vec, exp_vec());
            end
            n_cmp++;
        end
        pause = 1'b0;
        play  = 1'b1;
        do_cycle();
        play = 1'b0;
        cnt = 0;
        while (tone_en && cnt < 10) begin
            cnt++;
            do_cycle();
            if (w_dut_vec !== exp_vec()) begin
                n_bad++;
                $display("FAIL pause_resume cyc %0d: got %h want %h", cnt, w_dut_vec, exp_vec());
            end
            n_cmp++;
        end
        if (cnt !== 3 || playing !== 1'b1) begin
            n_bad++;
            $display("FAIL pause_remaining: got %0d cycles playing=%b want 3 cycles then GAP", cnt, playing);
        end
        n_cmp++;
        stop = 1'b1;
        do_cycle();
        stop = 1'b0;
    endtask

    task automatic test_priority();
        rom_p[0] = 4'd5; rom_d[0] = 2'd1;
        rom_p[1] = 4'd3; rom_d[1] = 2'd0;
        song_len = 5'd2;
        play = 1'b1;
        do_cycle();
        play = 1'b0;
        do_cycle();
        do_cycle();
        stop = 1'b1; pause = 1'b1; play = 1'b1;
        do_cycle();
        clear_inputs();
        if ({playing, tone_en, rom_addr, tone_pitch} !== 11'd0 || w_dut_vec !== exp_vec()) begin
            n_bad++;
            $display("FAIL prio_stop: got %h want %h", w_dut_vec, 12'h000);
        end
        n_cmp++;
        play = 1'b1;
        do_cycle();
        play = 1'b0;
        do_cycle();
        pause = 1'b1;
        do_cycle();
        play = 1'b1;
        for (int i = 0; i < 3; i++) begin
            do_cycle();
            if (playing !== 1'b0 || tone_en !== 1'b0 || w_dut_vec !== exp_vec()) begin
                n_bad++;
                $display("FAIL prio_paused cyc %0d: got %h want %h", i, w_dut_vec, exp_vec());
            end
            n_cmp++;
        end
        pause = 1'b0;
        do_cycle();
        play = 1'b0;
        if (tone_en !== 1'b1 || w_dut_vec !== exp_vec()) begin
            n_bad++;
            $display("FAIL prio_resume: got %h want %h", w_dut_vec, exp_vec());
        end
        n_cmp++;
        stop = 1'b1;
        do_cycle();
        stop = 1'b0;
    endtask

    task automatic test_empty_restart();
        song_len = 5'd0;
        play = 1'b1;
        do_cycle();
        play = 1'b0;
        if (done !== 1'b1 || tone_en !== 1'b0) begin
            n_bad++;
            $display("FAIL empty_done: got done=%b tone_en=%b want 1/0", done, tone_en);
        end
        n_cmp++;
        for (int i = 0; i < 3; i++) begin
            do_cycle();
            if (tone_en !== 1'b0 || done !== 1'b1) begin
                n_bad++;
                $display("FAIL empty_hold cyc %0d: got tone_en=%b done=%b want 0/1", i, tone_en, done);
            end
            n_cmp++;
        end
        song_len = 5'd2;
        play = 1'b1;
        do_cycle();
        play = 1'b0;
        if (playing !== 1'b1 || rom_addr !== 5'd0 || done !== 1'b0 || tone_en !== 1'b0) begin
            n_bad++;
            $display("FAIL restart_fetch: got %h want playing at addr 0", w_dut_vec);
        end
        n_cmp++;
        stop = 1'b1;
        do_cycle();
        stop = 1'b0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 32; i++) begin
            rom_p[i] = 4'($urandom_range(0, 15));
            rom_d[i] = 2'($urandom_range(0, 3));
        end
        song_len = 5'($urandom_range(1, 5));
        for (int i = 0; i < 800; i++) begin
            play  = ($urandom_range(0, 99) < 8);
            pause = ($urandom_range(0, 99) < 4);
            stop  = ($urandom_range(0, 99) < 1);
            if ($urandom_range(0, 49) == 0) loop = ~loop;
            if ($urandom_range(0, 99) == 0) song_len = 5'($urandom_range(0, 6));
            do_cycle();
            if (w_dut_vec !== exp_vec()) begin
                n_bad++;
                $display("FAIL random cyc %0d: got %h want %h", i, w_dut_vec, exp_vec());
            end
            n_cmp++;
        end
        clear_inputs();
    endtask

    initial begin
        for (int i = 0; i < 32; i++) begin
            rom_p[i] = '0;
            rom_d[i] = '0;
        end
        model_reset();
        test_reset();
        test_two_note();
        test_rest_loop();
        test_pause();
        test_priority();
        test_empty_restart();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
